uart_tx: RTL and testbench

//  Serialises one byte per request onto a UART line as 8N1: start bit 0, 8 data bits LSB first, stop bit 1.

---
 rtl/common.sv | 27 ++
 rtl/uart_tx.sv | 174 +++++++++++++++++
 tb/tb_uart_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/common.sv
// Package common: shared UART constants and the transmitter state encoding.
// Contents:
//   RESET                 active level of rst (synchronous, active-high)
//   NUM_DATA_BITS         data bits per frame (8)
//   BAUD_COUNT_CHECK      terminal count of the baud timer (clk cycles per bit - 1)
//   CLKS_PER_BIT_DEFAULT  clk cycles per bit, shared by the receiver and the transmitter
//   uart_tx_state_t       transmitter FSM states (ST_PARITY only with UART_TX_PARITY_EN)
// Configuration macro: UART_TX_PARITY_EN
package common;

  localparam logic        RESET                = 1'b1;
  localparam int unsigned NUM_DATA_BITS        = 8;
  // 50 MHz clk at 115200 baud -> 434 clk cycles per bit
  localparam int unsigned BAUD_COUNT_CHECK     = 433;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = BAUD_COUNT_CHECK + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: single-frame UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN).
// Serialises one byte per accepted request: start bit 0, 8 data bits LSB first,
// optional even parity bit, stop bit 1. No FIFO; upstream holds requests until busy is low.
//
// Configuration macro: UART_TX_PARITY_EN (defined -> parity bit inserted, 11-bit frame)
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
// Ports:
//   clk       in   clock
//   rst       in   synchronous reset, active-high
//   data      in   byte to send, sampled only in the accept cycle
//   tx_start  in   request, accepted when high while idle
//   tx        out  serial line, idle high (registered)
//   busy      out  high from the cycle after accept until the stop bit completes (registered)
//   done      out  one-cycle pulse on the last cycle of the stop bit (registered)
//
// State     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high, waiting for tx_start
// ST_START  | driving the start bit (0)
// ST_DATA   | driving shift_q[0], 8 bits LSB first
// ST_PARITY | driving even parity of the latched byte
// ST_STOP   | driving the stop bit (1); done on its last cycle
module uart_tx
  import common::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       tx_start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // done is registered, so it is armed one cycle before the last stop-bit cycle
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       BIT_LAST = 3'(NUM_DATA_BITS - 1);

  uart_tx_state_t           state_q, state_d;
  logic [CNT_W-1:0]         cycle_cnt_q, cycle_cnt_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
  logic                     tx_d, busy_d, done_d;
  logic                     bit_end;
`ifdef UART_TX_PARITY_EN
  logic                     parity_q, parity_d;
`endif

  assign bit_end = (cycle_cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx          <= tx_d;
      busy        <= busy_d;
      done        <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Outputs are registered, so every transition loads the value the line
  // must carry during the first cycle of the next bit.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx;
    busy_d      = busy;
    done_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (state_q != ST_IDLE) begin
      cycle_cnt_d = bit_end ? '0 : cycle_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          state_d     = ST_START;
          shift_d     = data;
          cycle_cnt_d = '0;
          bit_cnt_d   = '0;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d    = ^data;
`endif
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
            tx_d      = parity_q;
`else
            state_d   = ST_STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        tx_d = 1'b1;
        if (cycle_cnt_q == CNT_DONE) begin
          done_d = 1'b1;
        end
        if (bit_end) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cycle_cnt_d = '0;
        bit_cnt_d   = '0;
        tx_d        = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       tx_start;
  logic       tx, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_sent   = 0;
  int n_rx     = 0;
  int n_abort  = 0;

  logic [7:0] exp_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .tx_start (tx_start),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (busy !== 1'b0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("idle_timeout", 32'(busy), 32'(0));
    data     = b;
    tx_start = 1'b1;
    exp_q.push_back(b);
    n_sent++;
    @(posedge clk); #1;
    tx_start = 1'b0;
    data     = ~b;
    check("accept_busy", 32'(busy), 32'(1));
    check("accept_tx", 32'(tx), 32'(0));
  endtask

  // Returns at posedge+1 of the idle cycle that follows the done pulse.
  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("done_timeout", 32'(done), 32'(1));
    @(posedge clk); #1;
  endtask

  // Line receiver: decodes every frame seen on tx and checks framing,
  // bit timing, done/busy placement and the idle gap after each frame.
  initial begin
    logic [FRAME_BITS-1:0] bits;
    logic [7:0]            rx_byte, exp_byte;
    logic                  aborted, glitch, done_bad, busy_bad;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      aborted = 1'b0; glitch = 1'b0; done_bad = 1'b0; busy_bad = 1'b0;
      bits = '0;
      for (int i = 0; i < FRAME_CYC; i++) begin
        if (i != 0) @(negedge clk);
        if (rst !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        if (i % CPB == 0) bits[i / CPB] = tx;
        else if (tx !== bits[i / CPB]) glitch = 1'b1;
        if (done !== (i == FRAME_CYC - 1)) done_bad = 1'b1;
        if (busy !== 1'b1) busy_bad = 1'b1;
      end
      if (aborted) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        n_abort++;
        continue;
      end
      rx_byte = bits[8:1];
      n_rx++;
      check("bit_stable", 32'(glitch), 32'(0));
      check("done_pos", 32'(done_bad), 32'(0));
      check("busy_hold", 32'(busy_bad), 32'(0));
      check("start_bit", 32'(bits[0]), 32'(0));
      check("stop_bit", 32'(bits[FRAME_BITS-1]), 32'(1));
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(rx_byte), 32'h100);
      end else begin
        exp_byte = exp_q.pop_front();
        check("rx_byte", 32'(rx_byte), 32'(exp_byte));
`ifdef UART_TX_PARITY_EN
        check("parity_bit", 32'(bits[9]), 32'(^exp_byte));
`endif
      end
      @(negedge clk);
      check("idle_gap", {29'd0, tx, busy, done}, 32'b100);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_start = 1'b0; data = 8'h00;

    // reset held 3 cycles, then idle with no requests
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_out", {29'd0, tx, busy, done}, 32'b100);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("idle_out", {29'd0, tx, busy, done}, 32'b100);
    end

    // single frame, data changed right after accept
    send_byte(8'hA5);
    wait_done();

    // back-to-back with tx_start held high; pulses during busy ignored
    data = 8'h00; tx_start = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); n_sent += 2;
    @(posedge clk); #1;
    check("b2b_accept1", 32'(busy), 32'(1));
    data = 8'hFF;
    wait_done();
    @(posedge clk); #1;
    check("b2b_accept2", {30'd0, tx, busy}, 32'b01);
    tx_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; tx_start = 1'b1; data = 8'h12;
      @(posedge clk); #1; tx_start = 1'b0;
    end
    wait_done();

    // reset mid-DATA aborts the frame, then a clean frame follows
    send_byte(8'h3C);
    repeat (4 * CPB) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort", {30'd0, tx, busy}, 32'b10);
    rst = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h81);
    wait_done();

    // loopback byte set
    begin
      logic [7:0] lb [4] = '{8'h55, 8'h00, 8'hFF, 8'h3C};
      for (int i = 0; i < 4; i++) begin
        send_byte(lb[i]);
        wait_done();
      end
    end

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07);
    wait_done();
`endif

    repeat (10) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("abort_count", 32'(n_abort), 32'(1));
    check("rx_count", 32'(n_rx), 32'(n_sent - 1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
